// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake and FIFO write-side bundle for fifo_wr_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4,
  parameter int NREQ   = 4
);
  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ*DWIDTH-1:0] req_data_i;
  logic [NREQ-1:0]        req_ready_o;
  logic                   wr_full_i;
  logic [AWIDTH-1:0]      wr_usedw_i;
  logic                   wr_req_o;
  logic [DWIDTH-1:0]      wr_data_o;
  logic [NREQ-1:0]        grant_o;

  modport master (
    output req_valid_i, req_data_i, wr_full_i, wr_usedw_i,
    input  req_ready_o, wr_req_o, wr_data_o, grant_o
  );

  modport slave (
    input  req_valid_i, req_data_i, wr_full_i, wr_usedw_i,
    output req_ready_o, wr_req_o, wr_data_o, grant_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding several requesters into one FIFO write port.
// A grant is only issued when the FIFO has room for a whole burst plus two words of slack.
module fifo_wr_arbiter #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4,
  parameter int NREQ   = 4,
  parameter int BURST  = 4
) (
  input  logic             wr_clk_i,
  input  logic             aclr_i,
  fifo_wr_arbiter_if.slave bus
);
  localparam int CW  = $clog2(BURST + 1);
  localparam int PW  = $clog2(NREQ);
  localparam int AW1 = AWIDTH + 1;

  localparam logic [AW1-1:0] MAX_USED  = AW1'((2 ** AWIDTH) - 1);
  localparam logic [AW1-1:0] MIN_ROOM  = AW1'(BURST + 2);
  localparam logic [CW-1:0]  BURST_CNT = CW'(BURST);
  localparam logic [PW-1:0]  LAST_REQ  = PW'(NREQ - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            r_state, w_stateNext;
  logic [NREQ-1:0]   r_grant, w_grantNext;
  logic [PW-1:0]     r_gIdx, w_gIdxNext;
  logic [PW-1:0]     r_rrPtr, w_rrPtrNext;
  logic [CW-1:0]     r_count, w_countNext;
  logic              r_wrReq, w_wrReqNext;
  logic [DWIDTH-1:0] r_wrData, w_wrDataNext;

  logic [AW1-1:0]    w_headroom;
  logic              w_room;
  logic              w_found;
  logic [PW-1:0]     w_selIdx;
  logic              w_validG;
  logic              w_beat;
  logic [CW-1:0]     w_countInc;
  logic [DWIDTH-1:0] w_dataG;
  logic [NREQ-1:0]   w_ready;

  assign w_headroom = MAX_USED - {1'b0, bus.wr_usedw_i};
  assign w_room     = (w_headroom >= MIN_ROOM) && !bus.wr_full_i;
  assign w_validG   = bus.req_valid_i[r_gIdx];
  assign w_dataG    = bus.req_data_i[r_gIdx*DWIDTH +: DWIDTH];
  assign w_ready    = ((r_state == GRANT) && !bus.wr_full_i) ? r_grant : '0;
  assign w_beat     = (r_state == GRANT) && w_validG && !bus.wr_full_i;
  assign w_countInc = r_count + 1'b1;

  assign bus.req_ready_o = w_ready;
  assign bus.grant_o     = r_grant;
  assign bus.wr_req_o    = r_wrReq;
  assign bus.wr_data_o   = r_wrData;

  // Cyclic search for the first valid requester at or above the round-robin pointer.
  always_comb begin
    int idx;
    idx      = 0;
    w_found  = 1'b0;
    w_selIdx = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(r_rrPtr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && bus.req_valid_i[idx]) begin
        w_found  = 1'b1;
        w_selIdx = PW'(idx);
      end
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_grantNext  = r_grant;
    w_gIdxNext   = r_gIdx;
    w_rrPtrNext  = r_rrPtr;
    w_countNext  = r_count;
    w_wrReqNext  = 1'b0;
    w_wrDataNext = r_wrData;
    unique case (r_state)
      IDLE: begin
        if (w_room && w_found) begin
          w_stateNext = GRANT;
          w_grantNext = {{(NREQ-1){1'b0}}, 1'b1} << w_selIdx;
          w_gIdxNext  = w_selIdx;
          w_countNext = '0;
        end
      end
      GRANT: begin
        // Full stalls everything; otherwise a dropped valid or a completed burst releases.
        if (w_beat) begin
          w_wrReqNext  = 1'b1;
          w_wrDataNext = w_dataG;
          w_countNext  = w_countInc;
        end
        if ((w_beat && (w_countInc == BURST_CNT)) || (!bus.wr_full_i && !w_validG)) begin
          w_stateNext = IDLE;
          w_grantNext = '0;
          w_rrPtrNext = (r_gIdx == LAST_REQ) ? '0 : r_gIdx + 1'b1;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_grantNext = '0;
      end
    endcase
  end

  always_ff @(posedge wr_clk_i or negedge aclr_i) begin
    if (!aclr_i) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_gIdx   <= '0;
      r_rrPtr  <= '0;
      r_count  <= '0;
      r_wrReq  <= 1'b0;
      r_wrData <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_grant  <= w_grantNext;
      r_gIdx   <= w_gIdxNext;
      r_rrPtr  <= w_rrPtrNext;
      r_count  <= w_countNext;
      r_wrReq  <= w_wrReqNext;
      r_wrData <= w_wrDataNext;
    end
  end
endmodule
